byte_serial_adder: RTL
======================

Name: byte_serial_adder

Overview:
- Multi-cycle wide adder/subtractor that computes a WIDTH-bit add or subtract one byte per clock.
- Each cycle it feeds one byte slice of the latched operands, plus the registered carry, into the team's 8-bit ripple_carry_adder.
- It sits directly upstream of that adder, sequencing operands into it and collecting its sum and carry outputs.
- Purpose: wide arithmetic without a WIDTH-bit combinational carry chain.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 8.
- NBYTES (localparam), WIDTH/8, number of byte iterations.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0 = a+b+cin; 1 = a-b (computed as a + ~b + 1; cin ignored).
- a  input  WIDTH  operand A, latched at start acceptance.
- b  input  WIDTH  operand B, latched at start acceptance.
- cin  input  1  carry-in for add, latched at start acceptance.
- busy  output  1  high while bytes are being computed.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, held stable until the next accepted start.
- cout  output  1  carry out of the MSB.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0:
  - state=IDLE; busy, done, cout, overflow = 0; sum = 0.
  - Internal a_reg, b_reg, carry and byte index = 0.
- FSM states: IDLE, RUN, DONE.
- Acceptance, IDLE or DONE with start=1 at edge E0:
  - a_reg<=a; b_reg<=(sub ? ~b : b); carry<=(sub ? 1 : cin); idx<=0.
  - sum<=0; cout<=0; overflow<=0; busy<=1; state<=RUN.
- RUN, each edge E1..E(NBYTES):
  - The adder sees a_reg[8*idx+:8], b_reg[8*idx+:8] and carry.
  - sum[8*idx+:8] <= adder sum; carry <= adder cout; idx <= idx+1.
- At edge E(NBYTES), the final byte:
  - cout <= adder cout.
  - overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (adder sum[7] != a_reg[WIDTH-1]).
  - busy<=0; done<=1; state<=DONE.
- DONE: done is high for exactly one cycle.
  - Next edge: state<=IDLE and done<=0, unless start=1, which is accepted as above.
- Latency: done is visible NBYTES clock edges after the accepting edge (4 for WIDTH=32). Throughput: one operation per NBYTES+1 cycles.
- start while busy=1: ignored; operands and sub changes are also ignored mid-operation.
- start held high continuously: a new operation is accepted on every DONE cycle.
- Output stability: sum, cout and overflow are stable from the done cycle until the next acceptance edge, then cleared. Consumers must sample on done.
- Reset mid-RUN: immediate abort to reset values; no done pulse.
- idx width: clog2(NBYTES), minimum 1. WIDTH=8 degenerates to a single RUN cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DONE) and the byte-width constant 8.
- Sub-module: one instance of the existing ripple_carry_adder (8-bit) as the datapath.
  - Its inputs are driven by the byte slice muxes and the carry register.
  - The FSM and registers stay in byte_serial_adder.

Test Plan:
- Carry ripple across all bytes (WIDTH=32): a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 -> sum=0x00000000, cout=1, overflow=0; done exactly 4 edges after acceptance; busy high for 4 cycles.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0.
- Signed overflow and inter-byte carry:
  - 0x7FFFFFFF+0x00000001, cin=0 -> sum=0x80000000, overflow=1, cout=0.
  - 0x00FF00FF+0x00010001, cin=1 -> sum=0x01000101, cout=0.
- Ignored start: pulse start with a=1, b=1 at cycles 2 and 3 of a running 0x10+0x20 op -> result 0x00000030; exactly one done pulse; no extra acceptance.
- Reset and back-to-back:
  - Assert rst_n=0 mid-RUN -> busy, done, sum, cout and overflow go 0 immediately; no done after release.
  - Then hold start=1 -> new operation accepted on the DONE cycle, done pulses every 5 cycles.

Source files
------------

// File: rtl/byte_serial_adder_pkg.sv
// Shared definitions for the byte-serial adder/subtractor.
// Contains the FSM state encoding and the datapath slice width.
package byte_serial_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : byte_serial_adder_pkg

// File: rtl/byte_serial_adder_if.sv
// Request/result bundle for byte_serial_adder.
// The requester drives operands and start; the adder returns status and the result.
interface byte_serial_adder_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, overflow
  );

endinterface : byte_serial_adder_if

// File: rtl/ripple_carry_adder.sv
// 8-bit ripple-carry adder used as the byte datapath of byte_serial_adder.
// Purely combinational: sum = a + b + cin, cout is the carry out of bit 7.
module ripple_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[8];
  end

endmodule : ripple_carry_adder

// File: rtl/byte_serial_adder.sv
// WIDTH-bit add/subtract computed one byte per clock through an 8-bit ripple adder.
// Operands are latched on acceptance; the result is held until the next accepted start.
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  byte_serial_adder_if.slave  bus
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BYTE_W-1:0]  a_byte;
  logic [BYTE_W-1:0]  b_byte;
  logic [BYTE_W-1:0]  rca_sum;
  logic               rca_cout;

  // Byte-slice select for the current iteration.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte = a_q[i*BYTE_W +: BYTE_W];
        b_byte = b_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  ripple_carry_adder u_rca (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_q),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1, so the inversion and the +1 happen at latch time.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*BYTE_W +: BYTE_W] = rca_sum;
          end
        end
        carry_d = rca_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = rca_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (rca_sum[BYTE_W-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule : byte_serial_adder
